// File: rtl/neuron_core_pkg.sv
// Shared types for the neuron core Wishbone front-end:
// region encodings, decoder FSM states and default wait counts.
package neuron_core_pkg;

    typedef enum logic [1:0] {
        REG_SYNAP = 2'b00,
        REG_PARAM = 2'b01,
        REG_SPIKE = 2'b10,
        REG_CTRL  = 2'b11
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } dec_state_e;

    localparam int DEF_SYN_WAIT   = 1;
    localparam int DEF_PARAM_WAIT = 0;
    localparam int DEF_SPIKE_WAIT = 0;
    localparam int DEF_CTRL_WAIT  = 0;

endpackage

// File: rtl/wb_region_decoder_if.sv
// Wishbone classic slave-side bus bundle for the region decoder.
// Names mirror the Caravel wbs_* signals.
interface wb_region_decoder_if #(
    parameter int ADDR_W = 32
);
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [ADDR_W-1:0] wbs_adr_i;
    logic              wbs_ack_o;
    logic              wbs_err_o;

    modport slave (
        input  wbs_cyc_i,
        input  wbs_stb_i,
        input  wbs_we_i,
        input  wbs_adr_i,
        output wbs_ack_o,
        output wbs_err_o
    );

    modport master (
        output wbs_cyc_i,
        output wbs_stb_i,
        output wbs_we_i,
        output wbs_adr_i,
        input  wbs_ack_o,
        input  wbs_err_o
    );
endinterface

// File: rtl/wb_wait_counter.sv
// 4-bit loadable down-counter used to time per-region wait states.
// Saturates at zero; load has priority over enable.
module wb_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic [3:0] cnt,
    output logic       zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/wb_region_decoder.sv
// Wishbone slave front-end: decodes a bus cycle into a one-hot region
// select and parameter index, inserts wait states and drives ack/err.
module wb_region_decoder
    import neuron_core_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h3000_0000,
    parameter int              REGION_LSB = 13,
    parameter int              PIDX_LSB   = 4,
    parameter int              NUM_PARAMS = 32,
    parameter int              SYN_WAIT   = DEF_SYN_WAIT,
    parameter int              PARAM_WAIT = DEF_PARAM_WAIT,
    parameter int              SPIKE_WAIT = DEF_SPIKE_WAIT,
    parameter int              CTRL_WAIT  = DEF_CTRL_WAIT,
    localparam int             PIDX_W     =
        (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    wb_region_decoder_if.slave wbs,
    output logic              sel_synap_o,
    output logic              sel_param_o,
    output logic              sel_spike_o,
    output logic              sel_ctrl_o,
    output logic [PIDX_W-1:0] param_num_o,
    output logic              wr_en_o,
    output logic              rd_en_o,
    output logic              busy_o
);

    dec_state_e        state_q, state_d;
    region_e           region_q;
    logic [PIDX_W-1:0] idx_q;
    logic              we_q;
    logic              err_q;

    region_e           region;
    logic              base_ok;
    logic              hit;
    logic              bad_idx;
    logic [4:0]        pidx_field;
    logic [3:0]        wait_sel;
    logic [3:0]        wcnt;
    logic              wzero;
    logic              accept;
    logic              active;
    logic              resp_ok;
    logic              unused_adr;

    assign region  = region_e'(wbs.wbs_adr_i[REGION_LSB+1:REGION_LSB]);
    assign base_ok = wbs.wbs_adr_i[ADDR_W-1:REGION_LSB+2]
                  == BASE_ADDR[ADDR_W-1:REGION_LSB+2];
    assign hit     = wbs.wbs_cyc_i & wbs.wbs_stb_i & base_ok;

    // The range check always looks at the full 5-bit index field
    assign pidx_field = wbs.wbs_adr_i[PIDX_LSB+4:PIDX_LSB];
    assign bad_idx    = (region == REG_PARAM)
                     && (int'(pidx_field) >= NUM_PARAMS);

    assign accept = (state_q == ST_IDLE) && hit;

    always_comb begin
        wait_sel = 4'd0;
        unique case (region)
            REG_SYNAP: wait_sel = 4'(SYN_WAIT);
            REG_PARAM: wait_sel = 4'(PARAM_WAIT);
            REG_SPIKE: wait_sel = 4'(SPIKE_WAIT);
            REG_CTRL:  wait_sel = 4'(CTRL_WAIT);
        endcase
    end

    wb_wait_counter u_wcnt (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .load     (accept),
        .en       (state_q == ST_WAIT),
        .load_val (bad_idx ? 4'd0 : wait_sel),
        .cnt      (wcnt),
        .zero     (wzero)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= ST_IDLE;
            region_q <= REG_SYNAP;
            idx_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                region_q <= region;
                idx_q    <= (region == REG_PARAM)
                          ? wbs.wbs_adr_i[PIDX_LSB+PIDX_W-1:PIDX_LSB]
                          : '0;
                we_q     <= wbs.wbs_we_i;
                err_q    <= bad_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = (wait_sel != 4'd0 && !bad_idx)
                            ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                // Dropping cyc abandons the cycle without a response
                if (!wbs.wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (wcnt == 4'd1 || wzero) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign active  = (state_q != ST_IDLE) && !err_q;
    assign resp_ok = (state_q == ST_RESP) && !err_q;

    assign sel_synap_o = active && region_q == REG_SYNAP;
    assign sel_param_o = active && region_q == REG_PARAM;
    assign sel_spike_o = active && region_q == REG_SPIKE;
    assign sel_ctrl_o  = active && region_q == REG_CTRL;
    assign param_num_o = active ? idx_q : '0;

    assign wbs.wbs_ack_o = resp_ok;
    assign wbs.wbs_err_o = (state_q == ST_RESP) && err_q;
    assign wr_en_o       = resp_ok && we_q;
    assign rd_en_o       = resp_ok && !we_q;
    assign busy_o        = (state_q != ST_IDLE);

    assign unused_adr = ^wbs.wbs_adr_i;

endmodule

// File: tb/tb_wb_region_decoder.sv
// Directed bench for wb_region_decoder: NUM_PARAMS=20, SYN_WAIT=3,
// other regions zero-wait.
module tb_wb_region_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic sel_synap, sel_param, sel_spike, sel_ctrl;
    logic [4:0] param_num;
    logic wr_en, rd_en, busy;
    logic [8:0] obs;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_region_decoder_if #(.ADDR_W(32)) bus ();

    wb_region_decoder #(
        .NUM_PARAMS (20),
        .SYN_WAIT   (3),
        .PARAM_WAIT (0),
        .SPIKE_WAIT (0),
        .CTRL_WAIT  (0)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs         (bus.slave),
        .sel_synap_o (sel_synap),
        .sel_param_o (sel_param),
        .sel_spike_o (sel_spike),
        .sel_ctrl_o  (sel_ctrl),
        .param_num_o (param_num),
        .wr_en_o     (wr_en),
        .rd_en_o     (rd_en),
        .busy_o      (busy)
    );

    // ack err synap param spike ctrl wr rd busy
    assign obs = {bus.wbs_ack_o, bus.wbs_err_o, sel_synap, sel_param,
                  sel_spike, sel_ctrl, wr_en, rd_en, busy};

    localparam logic [8:0] O_IDLE  = 9'b000000000;
    localparam logic [8:0] O_SYNW  = 9'b001000001;
    localparam logic [8:0] O_SYNWR = 9'b101000101;
    localparam logic [8:0] O_PRD   = 9'b100100011;
    localparam logic [8:0] O_ERR   = 9'b010000001;
    localparam logic [8:0] O_CRD   = 9'b100001011;
    localparam logic [8:0] O_SRD   = 9'b100010011;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic c, input logic s, input logic w,
                       input logic [31:0] a);
        bus.wbs_cyc_i = c;
        bus.wbs_stb_i = s;
        bus.wbs_we_i  = w;
        bus.wbs_adr_i = a;
    endtask

    task automatic chk(input string tag, input logic [8:0] got,
                       input logic [8:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic chk_pn(input string tag, input logic [4:0] exp);
        checks++;
        assert (param_num === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, param_num, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req(0, 0, 0, 32'h0);
        #3;
        chk("reset_outs", obs, O_IDLE);
        chk_pn("reset_pnum", 5'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // synapse write, 3 waits; address change in WAIT is ignored
        req(1, 1, 1, 32'h3000_0000);
        tick();
        chk("syn_w1", obs, O_SYNW);
        bus.wbs_adr_i = 32'h3000_6000;
        tick();
        chk("syn_w2", obs, O_SYNW);
        tick();
        chk("syn_w3", obs, O_SYNW);
        tick();
        chk("syn_ack", obs, O_SYNWR);
        req(0, 0, 0, 32'h0);
        tick();
        chk("syn_after", obs, O_IDLE);

        // param read, idx 5
        req(1, 1, 0, 32'h3000_2050);
        tick();
        chk("par5_ack", obs, O_PRD);
        chk_pn("par5_pnum", 5'd5);
        req(0, 0, 0, 32'h0);
        tick();
        chk("par5_after", obs, O_IDLE);
        chk_pn("par5_pnum0", 5'd0);

        // back-to-back, highest legal idx 19
        req(1, 1, 0, 32'h3000_2130);
        tick();
        chk("b2b_ack1", obs, O_PRD);
        chk_pn("b2b_pnum", 5'd19);
        tick();
        chk("b2b_bubble", obs, O_IDLE);
        tick();
        chk("b2b_ack2", obs, O_PRD);
        req(0, 0, 0, 32'h0);
        tick();
        chk("b2b_after", obs, O_IDLE);

        // out-of-range idx 21 and boundary idx 20
        req(1, 1, 0, 32'h3000_2150);
        tick();
        chk("err21", obs, O_ERR);
        req(0, 0, 0, 32'h0);
        tick();
        chk("err21_after", obs, O_IDLE);
        req(1, 1, 1, 32'h3000_2140);
        tick();
        chk("err20", obs, O_ERR);
        req(0, 0, 0, 32'h0);
        tick();
        chk("err20_after", obs, O_IDLE);

        // base mismatch held 5 cycles
        req(1, 1, 1, 32'h3100_4000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("miss", obs, O_IDLE);
        end
        req(0, 0, 0, 32'h0);
        tick();

        // abort in second WAIT cycle
        req(1, 1, 1, 32'h3000_0000);
        tick();
        chk("abt_w1", obs, O_SYNW);
        tick();
        chk("abt_w2", obs, O_SYNW);
        req(0, 0, 1, 32'h3000_0000);
        tick();
        chk("abt_idle", obs, O_IDLE);
        tick();
        chk("abt_idle2", obs, O_IDLE);
        req(1, 1, 0, 32'h3000_6000);
        tick();
        chk("ctrl_ack", obs, O_CRD);
        req(0, 0, 0, 32'h0);
        tick();
        chk("ctrl_after", obs, O_IDLE);

        // async reset during WAIT
        req(1, 1, 1, 32'h3000_0000);
        tick();
        chk("rst_w1", obs, O_SYNW);
        rst_n = 1'b0;
        #1;
        chk("rst_async", obs, O_IDLE);
        req(0, 0, 0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rel", obs, O_IDLE);
        req(1, 1, 0, 32'h3000_4000);
        tick();
        chk("spk_ack", obs, O_SRD);
        req(0, 0, 0, 32'h0);
        tick();
        chk("spk_after", obs, O_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
